// File: rtl/vreg_pkg.sv
// rtl/vreg_pkg.sv - shared constants, clear-engine state type and lane helper for the vector register file
package vreg_pkg;

  localparam int DEF_NUM_VREGS = 8;
  localparam int DEF_LANES     = 4;
  localparam int DEF_WIDTH     = 32;

  typedef enum logic {
    CLR_IDLE,
    CLR_ACTIVE
  } clr_state_t;

  // Bit offset of a lane inside a packed vector.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/vector_reg_file_if.sv
// rtl/vector_reg_file_if.sv - write/read/scoreboard/clear signal bundle of the vector register file
interface vector_reg_file_if
  import vreg_pkg::*;
#(
  parameter int NUM_VREGS = DEF_NUM_VREGS,
  parameter int LANES     = DEF_LANES,
  parameter int WIDTH     = DEF_WIDTH
);
  localparam int VIDX_W = $clog2(NUM_VREGS);
  localparam int LIDX_W = $clog2(LANES);

  logic                   wr_en;
  logic [VIDX_W-1:0]      wr_vd;
  logic [LANES-1:0]       wr_mask;
  logic [LANES*WIDTH-1:0] wr_data;
  logic                   imm_en;
  logic [VIDX_W-1:0]      imm_vd;
  logic [LIDX_W-1:0]      imm_idx;
  logic [WIDTH-1:0]       imm_data;
  logic [VIDX_W-1:0]      vs1;
  logic [VIDX_W-1:0]      vs2;
  logic [LANES*WIDTH-1:0] rd1_data;
  logic [LANES*WIDTH-1:0] rd2_data;
  logic                   rd1_busy;
  logic                   rd2_busy;
  logic                   rsv_en;
  logic [VIDX_W-1:0]      rsv_vd;
  logic                   clr_start;
  logic                   clr_busy;

  modport master (
    output wr_en, wr_vd, wr_mask, wr_data, imm_en, imm_vd, imm_idx, imm_data,
           vs1, vs2, rsv_en, rsv_vd, clr_start,
    input  rd1_data, rd2_data, rd1_busy, rd2_busy, clr_busy
  );

  modport slave (
    input  wr_en, wr_vd, wr_mask, wr_data, imm_en, imm_vd, imm_idx, imm_data,
           vs1, vs2, rsv_en, rsv_vd, clr_start,
    output rd1_data, rd2_data, rd1_busy, rd2_busy, clr_busy
  );

endinterface

// File: rtl/vreg_read_port.sv
// rtl/vreg_read_port.sv - combinational read mux with same-cycle write bypass
module vreg_read_port
  import vreg_pkg::*;
#(
  parameter int NUM_VREGS = DEF_NUM_VREGS,
  parameter int LANES     = DEF_LANES,
  parameter int WIDTH     = DEF_WIDTH,
  localparam int VIDX_W   = $clog2(NUM_VREGS),
  localparam int LIDX_W   = $clog2(LANES)
) (
  input  logic [LANES*WIDTH-1:0] i_stored,
  input  logic [VIDX_W-1:0]      i_vs,
  input  logic                   i_wr_en,
  input  logic [VIDX_W-1:0]      i_wr_vd,
  input  logic [LANES-1:0]       i_wr_mask,
  input  logic [LANES*WIDTH-1:0] i_wr_data,
  input  logic                   i_imm_en,
  input  logic [VIDX_W-1:0]      i_imm_vd,
  input  logic [LIDX_W-1:0]      i_imm_idx,
  input  logic [WIDTH-1:0]       i_imm_data,
  output logic [LANES*WIDTH-1:0] o_data
);

  // Enables arrive already qualified: imm is only live when no vector write and not clearing.
  always_comb begin
    o_data = i_stored;
    if (i_wr_en && (i_vs == i_wr_vd)) begin
      for (int l = 0; l < LANES; l++) begin
        if (i_wr_mask[l]) begin
          o_data[lane_lsb(l, WIDTH) +: WIDTH] = i_wr_data[lane_lsb(l, WIDTH) +: WIDTH];
        end
      end
    end else if (i_imm_en && (i_vs == i_imm_vd)) begin
      o_data[lane_lsb(32'(i_imm_idx), WIDTH) +: WIDTH] = i_imm_data;
    end
  end

endmodule

// File: rtl/vector_reg_file.sv
// rtl/vector_reg_file.sv - vector register bank with masked/element writes, busy scoreboard and bulk clear
module vector_reg_file
  import vreg_pkg::*;
#(
  parameter int NUM_VREGS = DEF_NUM_VREGS,
  parameter int LANES     = DEF_LANES,
  parameter int WIDTH     = DEF_WIDTH,
  localparam int VIDX_W   = $clog2(NUM_VREGS)
) (
  input logic              clk,
  input logic              rst,
  vector_reg_file_if.slave bus
);

  logic [LANES*WIDTH-1:0] r_mem [NUM_VREGS];
  logic [NUM_VREGS-1:0]   r_busy;
  clr_state_t             r_state;
  logic [VIDX_W-1:0]      r_cnt;

  logic w_idle;
  logic w_wr_en;
  logic w_imm_en;
  logic w_rsv_en;

  assign w_idle   = (r_state == CLR_IDLE);
  assign w_wr_en  = w_idle && bus.wr_en;
  assign w_imm_en = w_idle && bus.imm_en && !bus.wr_en;
  assign w_rsv_en = w_idle && bus.rsv_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_VREGS; r++) begin
        r_mem[r] <= '0;
      end
      r_busy  <= '0;
      r_state <= CLR_IDLE;
      r_cnt   <= '0;
    end else if (r_state == CLR_ACTIVE) begin
      r_mem[r_cnt]  <= '0;
      r_busy[r_cnt] <= 1'b0;
      r_cnt         <= r_cnt + 1'b1;
      if (r_cnt == VIDX_W'(NUM_VREGS - 1)) begin
        r_state <= CLR_IDLE;
      end
    end else begin
      if (w_wr_en) begin
        for (int l = 0; l < LANES; l++) begin
          if (bus.wr_mask[l]) begin
            r_mem[bus.wr_vd][lane_lsb(l, WIDTH) +: WIDTH] <= bus.wr_data[lane_lsb(l, WIDTH) +: WIDTH];
          end
        end
      end else if (w_imm_en) begin
        r_mem[bus.imm_vd][lane_lsb(32'(bus.imm_idx), WIDTH) +: WIDTH] <= bus.imm_data;
      end
      // Reservation is placed after the release so a new producer wins on the same register.
      if (w_wr_en) begin
        r_busy[bus.wr_vd] <= 1'b0;
      end
      if (w_rsv_en) begin
        r_busy[bus.rsv_vd] <= 1'b1;
      end
      if (bus.clr_start) begin
        r_state <= CLR_ACTIVE;
        r_cnt   <= '0;
      end
    end
  end

  vreg_read_port #(.NUM_VREGS(NUM_VREGS), .LANES(LANES), .WIDTH(WIDTH)) u_rd1 (
    .i_stored  (r_mem[bus.vs1]),
    .i_vs      (bus.vs1),
    .i_wr_en   (w_wr_en),
    .i_wr_vd   (bus.wr_vd),
    .i_wr_mask (bus.wr_mask),
    .i_wr_data (bus.wr_data),
    .i_imm_en  (w_imm_en),
    .i_imm_vd  (bus.imm_vd),
    .i_imm_idx (bus.imm_idx),
    .i_imm_data(bus.imm_data),
    .o_data    (bus.rd1_data)
  );

  vreg_read_port #(.NUM_VREGS(NUM_VREGS), .LANES(LANES), .WIDTH(WIDTH)) u_rd2 (
    .i_stored  (r_mem[bus.vs2]),
    .i_vs      (bus.vs2),
    .i_wr_en   (w_wr_en),
    .i_wr_vd   (bus.wr_vd),
    .i_wr_mask (bus.wr_mask),
    .i_wr_data (bus.wr_data),
    .i_imm_en  (w_imm_en),
    .i_imm_vd  (bus.imm_vd),
    .i_imm_idx (bus.imm_idx),
    .i_imm_data(bus.imm_data),
    .o_data    (bus.rd2_data)
  );

  assign bus.rd1_busy = r_busy[bus.vs1];
  assign bus.rd2_busy = r_busy[bus.vs2];
  assign bus.clr_busy = (r_state == CLR_ACTIVE);

endmodule

// File: tb/tb_vector_reg_file.sv
// tb/tb_vector_reg_file.sv - randomized and directed self-checking bench for vector_reg_file
module tb_vector_reg_file;

  localparam int NUM = 8;
  localparam int LN  = 4;
  localparam int W   = 32;
  localparam int DW  = LN * W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vector_reg_file_if #(.NUM_VREGS(NUM), .LANES(LN), .WIDTH(W)) vif ();

  vector_reg_file #(.NUM_VREGS(NUM), .LANES(LN), .WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(vif.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_mem [NUM][LN];
  bit           m_busy[NUM];
  bit           m_clr;
  int           m_ptr;
  logic         s_clr_busy;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input int vs);
    logic [W-1:0]  lanes[LN];
    logic [DW-1:0] r;
    for (int l = 0; l < LN; l++) lanes[l] = m_mem[vs][l];
    if (!m_clr) begin
      if (vif.wr_en) begin
        if (vs == int'(vif.wr_vd)) begin
          for (int l = 0; l < LN; l++)
            if (vif.wr_mask[l]) lanes[l] = vif.wr_data[l*W +: W];
        end
      end else if (vif.imm_en && vs == int'(vif.imm_vd)) begin
        lanes[vif.imm_idx] = vif.imm_data;
      end
    end
    for (int l = 0; l < LN; l++) r[l*W +: W] = lanes[l];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] r;
    for (int l = 0; l < LN; l++) r[l*W +: W] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NUM; r++) begin
      for (int l = 0; l < LN; l++) m_mem[r][l] = '0;
      m_busy[r] = 1'b0;
    end
    m_clr = 1'b0;
    m_ptr = 0;
  endtask

  task automatic model_edge();
    if (m_clr) begin
      for (int l = 0; l < LN; l++) m_mem[m_ptr][l] = '0;
      m_busy[m_ptr] = 1'b0;
      m_ptr++;
      if (m_ptr == NUM) m_clr = 1'b0;
    end else begin
      if (vif.wr_en) begin
        for (int l = 0; l < LN; l++)
          if (vif.wr_mask[l]) m_mem[vif.wr_vd][l] = vif.wr_data[l*W +: W];
        m_busy[vif.wr_vd] = 1'b0;
      end else if (vif.imm_en) begin
        m_mem[vif.imm_vd][vif.imm_idx] = vif.imm_data;
      end
      if (vif.rsv_en) m_busy[vif.rsv_vd] = 1'b1;
      if (vif.clr_start) begin
        m_clr = 1'b1;
        m_ptr = 0;
      end
    end
  endtask

  task automatic idle_inputs();
    vif.wr_en = 0; vif.wr_vd = 0; vif.wr_mask = 0; vif.wr_data = 0;
    vif.imm_en = 0; vif.imm_vd = 0; vif.imm_idx = 0; vif.imm_data = 0;
    vif.rsv_en = 0; vif.rsv_vd = 0; vif.clr_start = 0;
  endtask

  task automatic rand_inputs();
    vif.wr_en     = ($urandom_range(0, 2) == 0);
    vif.wr_vd     = 3'($urandom_range(0, NUM - 1));
    vif.wr_mask   = 4'($urandom);
    vif.wr_data   = rand_vec();
    vif.imm_en    = ($urandom_range(0, 1) == 0);
    vif.imm_vd    = 3'($urandom_range(0, NUM - 1));
    vif.imm_idx   = 2'($urandom_range(0, LN - 1));
    vif.imm_data  = $urandom;
    vif.vs1       = 3'($urandom_range(0, NUM - 1));
    vif.vs2       = ($urandom_range(0, 3) == 0) ? vif.wr_vd : 3'($urandom_range(0, NUM - 1));
    vif.rsv_en    = ($urandom_range(0, 2) == 0);
    vif.rsv_vd    = ($urandom_range(0, 3) == 0) ? vif.wr_vd : 3'($urandom_range(0, NUM - 1));
    vif.clr_start = ($urandom_range(0, 49) == 0);
  endtask

  // Check everything against the model before the edge, then advance the model with the edge.
  task automatic step();
    @(negedge clk);
    check("rd1_data", vif.rd1_data, exp_read(int'(vif.vs1)));
    check("rd2_data", vif.rd2_data, exp_read(int'(vif.vs2)));
    check("rd1_busy", DW'(vif.rd1_busy), DW'(m_busy[vif.vs1]));
    check("rd2_busy", DW'(vif.rd2_busy), DW'(m_busy[vif.vs2]));
    check("clr_busy", DW'(vif.clr_busy), DW'(m_clr));
    s_clr_busy = vif.clr_busy;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic write_vec(input int vd, input logic [LN-1:0] mask, input logic [DW-1:0] data);
    idle_inputs();
    vif.wr_en = 1; vif.wr_vd = 3'(vd); vif.wr_mask = mask; vif.wr_data = data;
    step();
    idle_inputs();
  endtask

  task automatic count_clear(input string tag, input bit poke);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      idle_inputs();
      if (poke && i == 3) begin
        vif.wr_en = 1; vif.wr_vd = 0; vif.wr_mask = '1; vif.wr_data = rand_vec();
        vif.imm_en = 1; vif.rsv_en = 1; vif.rsv_vd = 2;
      end
      if (poke && i == 5) vif.clr_start = 1;
      step();
      if (s_clr_busy) cnt++;
    end
    idle_inputs();
    check(tag, DW'(cnt), DW'(NUM));
  endtask

  initial begin
    rst = 1'b1;
    vif.vs1 = 0; vif.vs2 = 0;
    idle_inputs();
    model_reset();
    #12;
    check("rst_rd1", vif.rd1_data, '0);
    check("rst_clr_busy", DW'(vif.clr_busy), '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NUM; i++) begin
      vif.vs1 = 3'(i); vif.vs2 = 3'(NUM - 1 - i);
      step();
    end

    // masked write with bypass
    write_vec(5, 4'hF, {4{32'hFF}});
    vif.wr_en = 1; vif.wr_vd = 5; vif.wr_mask = 4'b0101;
    vif.wr_data = {32'd4, 32'd3, 32'd2, 32'd1}; vif.vs1 = 5;
    #2;
    check("mask_bypass", vif.rd1_data, {32'hFF, 32'd3, 32'hFF, 32'd1});
    step();
    idle_inputs();
    #2;
    check("mask_stored", vif.rd1_data, {32'hFF, 32'd3, 32'hFF, 32'd1});
    step();

    // write priority
    vif.wr_en = 1; vif.wr_vd = 2; vif.wr_mask = 4'hF; vif.wr_data = {4{32'd7}};
    vif.imm_en = 1; vif.imm_vd = 3; vif.imm_idx = 1; vif.imm_data = 32'h99;
    vif.vs1 = 3; vif.vs2 = 2;
    step();
    idle_inputs();
    #2;
    check("prio_imm_dropped", DW'(vif.rd1_data[W +: W]), '0);
    check("prio_wr_done", vif.rd2_data, {4{32'd7}});
    step();

    // element write
    vif.imm_en = 1; vif.imm_vd = 3; vif.imm_idx = 2; vif.imm_data = 32'hABCD;
    #2;
    check("imm_bypass", vif.rd1_data, {32'd0, 32'hABCD, 32'd0, 32'd0});
    step();
    idle_inputs();

    // scoreboard
    vif.rsv_en = 1; vif.rsv_vd = 6; vif.vs1 = 6;
    step();
    idle_inputs();
    #2;
    check("busy_set", DW'(vif.rd1_busy), DW'(1));
    vif.rsv_en = 1; vif.rsv_vd = 6; vif.wr_en = 1; vif.wr_vd = 6; vif.wr_mask = 4'hF;
    vif.wr_data = rand_vec();
    step();
    idle_inputs();
    #2;
    check("busy_set_wins", DW'(vif.rd1_busy), DW'(1));
    vif.wr_en = 1; vif.wr_vd = 6; vif.wr_mask = 4'h0;
    step();
    idle_inputs();
    #2;
    check("busy_release", DW'(vif.rd1_busy), '0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      step();
    end
    idle_inputs();
    while (m_clr) step();

    // bulk clear
    for (int r = 0; r < NUM; r++) write_vec(r, 4'hF, {32'(r + 1), 32'hA5A5, 32'h1, 32'(r + 9)});
    vif.rsv_en = 1; vif.rsv_vd = 1; step();
    vif.rsv_en = 1; vif.rsv_vd = 4; step();
    idle_inputs();
    vif.clr_start = 1;
    step();
    count_clear("clr_len", 1'b1);
    for (int r = 0; r < NUM; r++) begin
      vif.vs1 = 3'(r);
      #2;
      check("clr_data", vif.rd1_data, '0);
      check("clr_busybit", DW'(vif.rd1_busy), '0);
      step();
    end

    // reset during clear
    for (int r = 0; r < NUM; r++) write_vec(r, 4'hF, rand_vec());
    vif.vs1 = 7; vif.vs2 = 6;
    vif.clr_start = 1;
    step();
    idle_inputs();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_clr_busy", DW'(vif.clr_busy), '0);
    check("rst_mid_rd1", vif.rd1_data, '0);
    check("rst_mid_rd2", vif.rd2_data, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vif.clr_start = 1;
    step();
    count_clear("clr_len_after_rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_reg_file.md
Name: vector_reg_file

Overview:
- Parametrised next-generation vector register bank for the vector CPU datapath. Depth, lane count and element width are configurable.
- Two combinational read ports with same-cycle write bypass.
- Write paths: full-vector write with per-lane mask, and single-element immediate write.
- Per-register busy scoreboard for hazard detection by decode.
- Sequential bulk-clear engine that zeroes the bank one register per cycle.

Parameters:
- NUM_VREGS, 8, number of vector registers (power of 2, >=2)
- LANES, 4, elements per vector register (power of 2, >=2)
- WIDTH, 32, bits per element
- Derived, not overridable: VIDX_W = $clog2(NUM_VREGS), LIDX_W = $clog2(LANES)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  full-vector write strobe
- wr_vd  in  VIDX_W  full-vector destination register
- wr_mask  in  LANES  per-lane write enable; bit i gates lane i
- wr_data  in  LANES*WIDTH  write data; lane i = bits [i*WIDTH +: WIDTH]
- imm_en  in  1  single-element write strobe
- imm_vd  in  VIDX_W  element write destination register
- imm_idx  in  LIDX_W  element write lane index
- imm_data  in  WIDTH  element write data
- vs1, vs2  in  VIDX_W  read port register selects
- rd1_data, rd2_data  out  LANES*WIDTH  read port data, same lane packing as wr_data
- rd1_busy, rd2_busy  out  1  scoreboard busy bit of vs1 / vs2
- rsv_en  in  1  reserve-destination strobe from issue
- rsv_vd  in  VIDX_W  register to mark busy
- clr_start  in  1  bulk-clear request pulse
- clr_busy  out  1  clear engine active

Behaviour:
- Reset: asynchronous and active-high; state is fixed regardless of clk.
  - All registers = 0; all busy bits = 0; clear FSM in IDLE; clear counter = 0.
  - Consequences: clr_busy = 0; rd*_data = 0; rd*_busy = 0.
- Write priority:
  - wr_en beats imm_en in the same cycle; the imm write is dropped, even if it targets a different register.
- Full-vector write:
  - At the clk edge with wr_en=1, lane i of wr_vd is updated iff wr_mask[i]=1. Other lanes are unchanged.
  - wr_mask = 0 updates no data, but still releases busy (see Scoreboard).
- Element write:
  - With imm_en=1 and wr_en=0, element [imm_vd][imm_idx] <= imm_data at the edge.
- Reads: combinational, with bypass.
  - If wr_en=1 and vsN == wr_vd, masked lanes return wr_data; unmasked lanes return stored data.
  - Else if imm_en=1 (wr_en=0), vsN == imm_vd: lane imm_idx returns imm_data.
  - Otherwise stored contents are returned.
  - Both ports are independent and may select the same register.
- Scoreboard:
  - busy[rsv_vd] is set at the edge with rsv_en=1.
  - busy[wr_vd] is cleared at the edge with wr_en=1.
  - imm writes do not touch busy.
  - rsv_en and wr_en to the same register in the same cycle: set wins (new producer).
  - rdN_busy = busy[vsN], registered value with no bypass.
- Clear engine FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_start=1. Counter cnt <= 0.
  - In CLEAR, each cycle: all lanes of register cnt <= 0, busy[cnt] <= 0, cnt <= cnt+1.
  - CLEAR -> IDLE after cycle with cnt == NUM_VREGS-1.
  - Duration is exactly NUM_VREGS cycles.
  - clr_busy = 1 whenever state == CLEAR, so it is high the cycle after the start edge.
  - clr_start while in CLEAR is ignored; there is no restart.
  - In CLEAR, wr_en, imm_en and rsv_en are ignored: no data or busy update, and no read bypass from them.
  - Reads in CLEAR return stored contents.
  - Counter wrap is never observed, because the FSM exits at NUM_VREGS-1.
- rst asserted mid-CLEAR: immediate return to IDLE; all state reset as above.
- Latency:
  - Written data is visible in the same cycle via bypass, and from storage from the next cycle.
  - Busy is visible the cycle after rsv_en.

Decomposition:
- Package vreg_pkg:
  - default parameter constants
  - clr_state_t enum {CLR_IDLE, CLR_ACTIVE}
  - helper function for lane slice extraction
- Sub-module vreg_read_port: one combinational read/bypass mux, instantiated twice (rd1, rd2).
- Storage, scoreboard and FSM live in the top module.

Test Plan:
- Reset then read: rst=1 -> 0 -> all vs select: rd*_data=0, rd*_busy=0, clr_busy=0.
- Masked write and bypass: wr_en, wr_vd=5, wr_mask=4'b0101, wr_data lanes {D,C,B,A}={4,3,2,1} after reg 5 is all 0xFF.
  - Same cycle, vs1=5: rd1 lanes = {0xFF,3,0xFF,1}.
  - Next cycle: identical value from storage.
- Priority: wr_en(vd=2, mask=F, data all 7) with imm_en(vd=3, idx=1, data=0x99) in the same cycle -> reg 3 lane1 unchanged; reg 2 = all 7.
- Scoreboard: rsv_en vd=6 -> next cycle rd1_busy=1 with vs1=6.
  - Same-cycle rsv_en and wr_en vd=6: still busy.
  - wr_en alone vd=6: busy=0 next cycle.
- Clear: fill all regs with nonzero data, reserve regs 1 and 4, pulse clr_start.
  - clr_busy high exactly 8 cycles; wr_en issued mid-clear has no effect.
  - Afterwards all regs 0 and all busy bits 0.
- Reset mid-clear: assert rst during cycle 3 of CLEAR -> clr_busy=0 immediately, all regs 0; a new clr_start after reset runs a full 8 cycles.
